fccc_lock_sequencer: RTL and testbench



---
 rtl/fccc_seq_pkg.sv | 18 +
 rtl/fccc_lock_sync.sv | 24 ++
 rtl/fccc_lock_sequencer.sv | 145 ++++++++++++++
 tb/tb_fccc_lock_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fccc_seq_pkg.sv
// rtl/fccc_seq_pkg.sv - shared state encoding and width helper for the CCC lock sequencer
package fccc_seq_pkg;

  localparam int MAX_CH = 8;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'b00,
    ST_FILTER    = 2'b01,
    ST_RELEASE   = 2'b10,
    ST_RUN       = 2'b11
  } seq_state_e;

  // Bits needed for a counter running 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fccc_lock_sync.sv
// rtl/fccc_lock_sync.sv - multi-bit, multi-stage synchroniser for raw CCC LOCK signals
module fccc_lock_sync #(
  parameter int W      = 2,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o
);

  logic [STAGES-1:0][W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/fccc_lock_sequencer.sv
// rtl/fccc_lock_sequencer.sv - lock filter and ordered per-channel reset release; FCCC_SEQ_LOSS_CNT_EN adds loss counters
module fccc_lock_sequencer
  import fccc_seq_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int FILTER_CYCLES = 1024,
  parameter int GAP_CYCLES    = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 8
) (
  input  logic                    PCLK,
  input  logic                    PRESET_N,
  input  logic [NUM_CH-1:0]       LOCK_IN,
  input  logic                    FORCE_RST,
  input  logic                    LOSS_CLR,
  output logic [NUM_CH-1:0]       CH_RST_N,
  output logic                    ALL_READY,
  output logic [1:0]              STATE,
  output logic [NUM_CH*CNT_W-1:0] LOSS_CNT
);

  localparam int FW = cnt_width(FILTER_CYCLES);
  localparam int GW = cnt_width(GAP_CYCLES);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  logic [NUM_CH-1:0] lock_s;
  logic              all_lk;

  seq_state_e        state_q, state_d;
  logic [FW-1:0]     filt_q, filt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [NUM_CH-1:0] rst_q, rst_d, rst_next;

  fccc_lock_sync #(
    .W      (NUM_CH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (PCLK),
    .rst_ni  (PRESET_N),
    .async_i (LOCK_IN),
    .sync_o  (lock_s)
  );

  assign all_lk   = &lock_s;
  // Channels are released strictly in order, so the next mask is a one-bit left fill.
  assign rst_next = (rst_q << 1) | NUM_CH'(1);

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    gap_d   = gap_q;
    rst_d   = rst_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        rst_d = '0;
        if (all_lk) begin
          state_d = ST_FILTER;
          filt_d  = '0;
        end
      end
      ST_FILTER: begin
        filt_d = filt_q + 1'b1;
        if (filt_q == FILT_LAST) begin
          rst_d   = NUM_CH'(1);
          gap_d   = '0;
          state_d = (NUM_CH > 1) ? ST_RELEASE : ST_RUN;
        end
      end
      ST_RELEASE: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          rst_d = rst_next;
          if (rst_next[NUM_CH-1]) state_d = ST_RUN;
        end
      end
      ST_RUN: rst_d = '1;
      default: begin
        state_d = ST_WAIT_LOCK;
        rst_d   = '0;
      end
    endcase
    // Any lock drop or forced restart outside WAIT_LOCK pulls every reset at once.
    if (state_q != ST_WAIT_LOCK && (!all_lk || FORCE_RST)) begin
      state_d = ST_WAIT_LOCK;
      rst_d   = '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state_q <= ST_WAIT_LOCK;
      filt_q  <= '0;
      gap_q   <= '0;
      rst_q   <= '0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      gap_q   <= gap_d;
      rst_q   <= rst_d;
    end
  end

  assign CH_RST_N  = rst_q;
  assign ALL_READY = (state_q == ST_RUN);
  assign STATE     = state_q;

`ifdef FCCC_SEQ_LOSS_CNT_EN
  logic [NUM_CH-1:0]            prev_q;
  logic [NUM_CH-1:0]            fall;
  logic [NUM_CH-1:0][CNT_W-1:0] loss_q, loss_d;

  assign fall = prev_q & ~lock_s;

  // A clear coinciding with a drop loads 1 so that drop is still counted.
  always_comb begin
    loss_d = loss_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (LOSS_CLR) begin
        loss_d[i] = fall[i] ? CNT_W'(1) : '0;
      end else if (fall[i] && (loss_q[i] != '1)) begin
        loss_d[i] = loss_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      prev_q <= '0;
      loss_q <= '0;
    end else begin
      prev_q <= lock_s;
      loss_q <= loss_d;
    end
  end

  assign LOSS_CNT = loss_q;
`else
  logic unused_loss_clr;
  assign unused_loss_clr = LOSS_CLR;
  assign LOSS_CNT        = '0;
`endif

endmodule

// File: tb/tb_fccc_lock_sequencer.sv
// tb/tb_fccc_lock_sequencer.sv - self-checking bench for fccc_lock_sequencer
module tb_fccc_lock_sequencer;

  localparam int N    = 3;
  localparam int F    = 8;
  localparam int G    = 4;
  localparam int S    = 2;
  localparam int CW   = 4;
  localparam int EMAX = F + 1 + G * (N - 1);
  localparam int LMAX = (1 << CW) - 1;
`ifdef FCCC_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic            PCLK;
  logic            PRESET_N;
  logic [N-1:0]    LOCK_IN;
  logic            FORCE_RST;
  logic            LOSS_CLR;
  logic [N-1:0]    CH_RST_N;
  logic            ALL_READY;
  logic [1:0]      STATE;
  logic [N*CW-1:0] LOSS_CNT;

  fccc_lock_sequencer #(
    .NUM_CH        (N),
    .FILTER_CYCLES (F),
    .GAP_CYCLES    (G),
    .SYNC_STAGES   (S),
    .CNT_W         (CW)
  ) dut (
    .PCLK      (PCLK),
    .PRESET_N  (PRESET_N),
    .LOCK_IN   (LOCK_IN),
    .FORCE_RST (FORCE_RST),
    .LOSS_CLR  (LOSS_CLR),
    .CH_RST_N  (CH_RST_N),
    .ALL_READY (ALL_READY),
    .STATE     (STATE),
    .LOSS_CNT  (LOSS_CNT)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks   = 0;
  int failures = 0;

  // Reference: e counts consecutive clean edges since leaving WAIT_LOCK.
  int         e;
  logic [N-1:0] dl [0:S];
  int         lm [N];

  typedef struct {
    logic [2:0]  lock;
    bit          frc;
    int          cyc;
    logic [2:0]  rst;
    logic [1:0]  st;
    bit          rdy;
    logic [11:0] loss;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    e = 0;
    for (int k = 0; k <= S; k++) dl[k] = '0;
    for (int i = 0; i < N; i++) lm[i] = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] ls, fall;
    bit all_lk;
    ls     = dl[S-1];
    fall   = dl[S] & ~ls;
    all_lk = &ls;
    if (e == 0) e = all_lk ? 1 : 0;
    else if (!all_lk || FORCE_RST) e = 0;
    else if (e < EMAX) e++;
    for (int i = 0; i < N; i++) begin
      if (LOSS_CLR) lm[i] = fall[i] ? 1 : 0;
      else if (fall[i]) lm[i] = (lm[i] < LMAX) ? lm[i] + 1 : LMAX;
    end
    for (int k = S; k > 0; k--) dl[k] = dl[k-1];
    dl[0] = LOCK_IN;
  endtask

  function automatic logic [17:0] model_exp();
    int n;
    logic [2:0] r;
    logic [1:0] st;
    logic [11:0] l;
    n = (e <= F) ? 0 : 1 + (e - F - 1) / G;
    if (n > N) n = N;
    r  = 3'((1 << n) - 1);
    st = (e == 0) ? 2'd0 : (e <= F) ? 2'd1 : (n < N) ? 2'd2 : 2'd3;
    l  = '0;
    for (int i = 0; i < N; i++) l[i*CW +: CW] = LOSS_EN ? CW'(lm[i]) : '0;
    return {r, st, st == 2'd3, l};
  endfunction

  task automatic step();
    @(posedge PCLK);
    model_edge();
    #1;
    check("model", 32'({CH_RST_N, STATE, ALL_READY, LOSS_CNT}), 32'(model_exp()));
  endtask

  task automatic apply_row(input int i);
    LOCK_IN   = tbl[i].lock;
    FORCE_RST = tbl[i].frc;
    repeat (tbl[i].cyc) step();
    check($sformatf("row%0d_rst", i), 32'(CH_RST_N), 32'(tbl[i].rst));
    check($sformatf("row%0d_state", i), 32'(STATE), 32'(tbl[i].st));
    check($sformatf("row%0d_ready", i), 32'(ALL_READY), 32'(tbl[i].rdy));
    check($sformatf("row%0d_loss", i), 32'(LOSS_CNT), LOSS_EN ? 32'(tbl[i].loss) : 32'd0);
    FORCE_RST = 1'b0;
  endtask

  initial begin
    // Power-up sequence and restart
    tbl[0]  = '{3'b111, 1'b0, 10, 3'b000, 2'b01, 1'b0, 12'h000};
    tbl[1]  = '{3'b111, 1'b0,  1, 3'b001, 2'b10, 1'b0, 12'h000};
    tbl[2]  = '{3'b111, 1'b0,  4, 3'b011, 2'b10, 1'b0, 12'h000};
    tbl[3]  = '{3'b111, 1'b0,  4, 3'b111, 2'b11, 1'b1, 12'h000};
    // Lock loss in RUN on channel 2
    tbl[4]  = '{3'b011, 1'b0,  2, 3'b111, 2'b11, 1'b1, 12'h000};
    tbl[5]  = '{3'b011, 1'b0,  1, 3'b000, 2'b00, 1'b0, 12'h100};
    // Back to RUN, then FORCE_RST
    tbl[6]  = '{3'b111, 1'b0, 19, 3'b111, 2'b11, 1'b1, 12'h100};
    tbl[7]  = '{3'b111, 1'b1,  1, 3'b000, 2'b00, 1'b0, 12'h100};
    tbl[8]  = '{3'b111, 1'b0,  1, 3'b000, 2'b01, 1'b0, 12'h100};
    tbl[9]  = '{3'b111, 1'b0,  7, 3'b000, 2'b01, 1'b0, 12'h100};
    tbl[10] = '{3'b111, 1'b0,  1, 3'b001, 2'b10, 1'b0, 12'h100};
    // Channel 1 drops for 3 cycles during FILTER, full filter afterwards
    tbl[11] = '{3'b111, 1'b1,  1, 3'b000, 2'b00, 1'b0, 12'h100};
    tbl[12] = '{3'b111, 1'b0,  2, 3'b000, 2'b01, 1'b0, 12'h100};
    tbl[13] = '{3'b101, 1'b0,  3, 3'b000, 2'b00, 1'b0, 12'h110};
    tbl[14] = '{3'b111, 1'b0, 10, 3'b000, 2'b01, 1'b0, 12'h110};
    tbl[15] = '{3'b111, 1'b0,  1, 3'b001, 2'b10, 1'b0, 12'h110};

    PRESET_N  = 1'b0;
    LOCK_IN   = '0;
    FORCE_RST = 1'b0;
    LOSS_CLR  = 1'b0;
    model_reset();
    repeat (2) @(posedge PCLK);
    #1;
    check("reset_outputs", 32'({CH_RST_N, STATE, ALL_READY, LOSS_CNT}), 32'd0);
    PRESET_N = 1'b1;

    for (int i = 0; i < 16; i++) apply_row(i);

    // Saturation on channel 0
    for (int p = 0; p < 20; p++) begin
      LOCK_IN = 3'b110;
      step();
      LOCK_IN = 3'b111;
      step();
    end
    repeat (3) step();
    check("loss_saturated", 32'(LOSS_CNT), LOSS_EN ? 32'h11F : 32'd0);

    // Clear coincident with a channel 0 drop
    LOCK_IN = 3'b110;
    step();
    LOCK_IN = 3'b111;
    step();
    LOSS_CLR = 1'b1;
    step();
    LOSS_CLR = 1'b0;
    check("loss_clr_with_drop", 32'(LOSS_CNT), LOSS_EN ? 32'h001 : 32'd0);

    // Asynchronous reset in the middle of RELEASE
    repeat (4) step();
    FORCE_RST = 1'b1;
    step();
    FORCE_RST = 1'b0;
    repeat (13) step();
    check("pre_async_rst", 32'(CH_RST_N), 32'h3);
    #2;
    PRESET_N = 1'b0;
    #1;
    check("async_reset_outputs", 32'({CH_RST_N, STATE, ALL_READY, LOSS_CNT}), 32'd0);
    model_reset();
    @(posedge PCLK);
    #1;
    PRESET_N = 1'b1;
    for (int i = 0; i < 4; i++) apply_row(i);

    // Randomised traffic against the reference
    for (int c = 0; c < 600; c++) begin
      LOCK_IN   = ($urandom_range(0, 29) == 0) ? 3'($urandom) : 3'b111;
      FORCE_RST = ($urandom_range(0, 49) == 0);
      LOSS_CLR  = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
